// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
// Holds the sequencer state encoding, the APB bus widths and the width helper.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans upward from last_idx+1 (mod N_REQ)
// and returns the first requesting index as both a one-hot vector and an index.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  always_comb begin
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    // Distance 1 is the requester right after the previous owner; distance
    // N_REQ wraps back to the previous owner itself, so it has lowest priority.
    for (int d = 1; d <= N_REQ; d++) begin
      cand = (int'(last_idx) + d) % N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_req && (i == cand) && req[i]) begin
          any_req    = 1'b1;
          gnt[i]     = 1'b1;
          gnt_idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter in front of an APB master: grants one requester at a time,
// runs SETUP/ACCESS with wait states, and turns a hung slave into an error completion.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [APB_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [APB_DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_done,
  output logic [APB_DATA_W-1:0]       req_rdata,
  output logic                        req_err,
  output logic [N_REQ-1:0]            grant,
  output logic                        timeout_evt,
  output logic                        apbm_sel,
  output logic                        apbm_enable,
  output logic                        apbm_write,
  output logic [APB_ADDR_W-1:0]       apbm_addr,
  output logic [APB_DATA_W-1:0]       apbm_wdata,
  input  logic [APB_DATA_W-1:0]       apbm_rdata,
  input  logic                        apbm_ready,
  input  logic                        apbm_slverr
);

  localparam int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic                    sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    write_q, write_d;
  logic [APB_ADDR_W-1:0]   addr_q, addr_d;
  logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [N_REQ-1:0]        pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [APB_ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [APB_DATA_W-1:0]   wdata_arr [N_REQ];
  logic                    sel_write;
  logic [APB_ADDR_W-1:0]   sel_addr;
  logic [APB_DATA_W-1:0]   sel_wdata;

  logic                    done_hit;
  logic                    to_hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[APB_ADDR_W*gi +: APB_ADDR_W];
    assign wdata_arr[gi] = req_wdata[APB_DATA_W*gi +: APB_DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req      (req_valid),
    .last_idx (last_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .any_req  (pick_any)
  );

  // Payload mux driven by the one-hot pick, avoiding a variable part-select.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_write = req_write[i];
        sel_addr  = addr_arr[i];
        sel_wdata = wdata_arr[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    sel_d       = sel_q;
    en_d        = en_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    done_hit    = 1'b0;
    to_hit      = 1'b0;
    req_done    = '0;
    req_rdata   = '0;
    req_err     = 1'b0;
    timeout_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_SETUP;
          grant_d = pick_gnt;
          last_d  = pick_idx;
          sel_d   = 1'b1;
          en_d    = 1'b0;
          write_d = sel_write;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        // A ready slave wins over a watchdog expiring in the same cycle.
        if (apbm_ready) begin
          done_hit = 1'b1;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          to_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done_hit || to_hit) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
          en_d    = 1'b0;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_hit || to_hit) begin
      req_done = grant_q;
    end
    if (done_hit && !write_q) begin
      req_rdata = apbm_rdata;
    end
    req_err     = done_hit ? apbm_slverr : to_hit;
    timeout_evt = to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign apbm_sel    = sel_q;
  assign apbm_enable = en_q;
  assign apbm_write  = write_q;
  assign apbm_addr   = addr_q;
  assign apbm_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: the stimulus side predicts each transfer
// from round-robin and timing rules; a negedge monitor checks the DUT every cycle.
module tb_apb_req_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [16*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_wdata = '0;
  logic [N-1:0]    req_done;
  logic [31:0]     req_rdata;
  logic            req_err;
  logic [N-1:0]    grant;
  logic            timeout_evt;
  logic            apbm_sel;
  logic            apbm_enable;
  logic            apbm_write;
  logic [15:0]     apbm_addr;
  logic [31:0]     apbm_wdata;
  logic [31:0]     apbm_rdata = '0;
  logic            apbm_ready = 1'b0;
  logic            apbm_slverr = 1'b0;

  apb_req_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_done    (req_done),
    .req_rdata   (req_rdata),
    .req_err     (req_err),
    .grant       (grant),
    .timeout_evt (timeout_evt),
    .apbm_sel    (apbm_sel),
    .apbm_enable (apbm_enable),
    .apbm_write  (apbm_write),
    .apbm_addr   (apbm_addr),
    .apbm_wdata  (apbm_wdata),
    .apbm_rdata  (apbm_rdata),
    .apbm_ready  (apbm_ready),
    .apbm_slverr (apbm_slverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;       // cycle in which the request was arbitrated
    int          done_c;  // cycle of the completion strobe
    int          id;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  bit          vld [N];
  logic        pw  [N];
  logic [15:0] pa  [N];
  logic [31:0] pd  [N];
  int          last_w = N - 1;
  int          cur = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        f;
  logic        e_sel, e_en, e_to, e_err;
  logic [N-1:0] e_gnt, e_done;
  logic [31:0] e_rd;

  always @(negedge clk) begin
    if (mon_en) begin
      e_sel = 1'b0; e_en = 1'b0; e_to = 1'b0; e_err = 1'b0;
      e_gnt = '0; e_done = '0; e_rd = '0;
      if (exp_q.size() > 0) begin
        f = exp_q[0];
        if (cyc > f.t) begin
          e_sel = 1'b1;
          e_en  = (cyc > f.t + 1);
          e_gnt = N'(1) << f.id;
        end
        if (cyc == f.done_c) begin
          e_done = N'(1) << f.id;
          e_rd   = f.rdata;
          e_err  = f.err;
          e_to   = f.to;
          void'(exp_q.pop_front());
        end
      end
      chk("ctrl", {apbm_sel, apbm_enable, grant, req_done, timeout_evt, req_err},
                  {e_sel, e_en, e_gnt, e_done, e_to, e_err});
      chk("rdata", req_rdata, e_rd);
      if (e_sel)
        chk("payload", {apbm_write, apbm_addr, apbm_wdata}, {f.wr, f.addr, f.wdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pay(input int i);
    pw[i] = 1'($urandom_range(0, 1));
    pa[i] = 16'($urandom);
    pd[i] = $urandom;
  endtask

  // Idle and granted requesters put garbage on their payload lines.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!vld[i] || i == cur) rand_pay(i);
      req_valid[i]          = vld[i];
      req_write[i]          = pw[i];
      req_addr[16*i +: 16]  = pa[i];
      req_wdata[32*i +: 32] = pd[i];
    end
  endtask

  task automatic slave_noise();
    apbm_ready  = 1'($urandom_range(0, 1));
    apbm_rdata  = $urandom;
    apbm_slverr = 1'($urandom_range(0, 1));
  endtask

  function automatic int pick();
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (last_w + d) % N;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit any_vld();
    for (int i = 0; i < N; i++) if (vld[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Called in an idle cycle with at least one request presented. k = number of
  // not-ready ACCESS cycles before ready; k >= TO means the slave never answers.
  task automatic xfer(input int k, input logic [31:0] rd, input logic se,
                      input bit drop, output int w);
    exp_t e;
    w = pick();
    last_w = w;
    e.t = cyc; e.id = w; e.wr = pw[w]; e.addr = pa[w]; e.wdata = pd[w];
    if (k >= TO) begin
      e.done_c = cyc + 1 + TO; e.to = 1'b1; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.done_c = cyc + 2 + k; e.to = 1'b0; e.err = se; e.rdata = e.wr ? 32'h0 : rd;
    end
    exp_q.push_back(e);
    step();
    cur = w;
    if (drop) vld[w] = 1'b0;
    drive();
    slave_noise();
    for (int j = 0; j <= ((k >= TO) ? TO - 1 : k); j++) begin
      step();
      drive();
      if (k < TO && j == k) begin
        apbm_ready = 1'b1; apbm_rdata = rd; apbm_slverr = se;
      end else begin
        apbm_ready = 1'b0; apbm_rdata = $urandom; apbm_slverr = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Cycle after a completion: requesters decide their next request.
  task automatic arb_cycle(input int w);
    step();
    cur = -1;
    vld[w] = 1'($urandom_range(0, 1));
    if (vld[w]) rand_pay(w);
    for (int i = 0; i < N; i++)
      if (i != w && !vld[i] && $urandom_range(0, 2) == 0) vld[i] = 1'b1;
    while (!any_vld()) begin
      drive();
      slave_noise();
      step();
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) vld[i] = 1'b1;
    end
    drive();
    slave_noise();
  endtask

  task automatic next_req(input bit v0, input bit v1);
    step();
    cur = -1;
    vld[0] = v0;
    vld[1] = v1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w;
    drive();
    repeat (3) step();
    chk("reset_outs", {req_done, grant, req_err, timeout_evt, apbm_sel, apbm_enable,
                       apbm_write, apbm_addr, apbm_wdata, req_rdata}, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single write, no wait states
    next_req(1'b1, 1'b0);
    pw[0] = 1'b1; pa[0] = 16'h0004; pd[0] = 32'h0000_0041;
    drive();
    xfer(0, 32'h1234_5678, 1'b0, 1'b0, w);

    // read from requester 1 with 3 wait states and a slave error
    next_req(1'b0, 1'b1);
    pw[1] = 1'b0; pa[1] = 16'h0010;
    drive();
    xfer(3, 32'hCAFE_F00D, 1'b1, 1'b0, w);

    // both requesters contending continuously
    next_req(1'b1, 1'b1);
    drive();
    for (int n = 0; n < 4; n++) begin
      xfer(0, $urandom, 1'b0, 1'b0, w);
      next_req(1'b1, 1'b1);
      rand_pay(w);
      drive();
    end
    xfer(0, $urandom, 1'b0, 1'b0, w);

    // watchdog abort, then a ready arriving on the last permitted cycle
    next_req(1'b1, 1'b0);
    drive();
    xfer(TO, $urandom, 1'b0, 1'b0, w);
    next_req(1'b1, 1'b0);
    pw[0] = 1'b0;
    drive();
    xfer(TO - 1, 32'h0BAD_BEEF, 1'b0, 1'b0, w);

    // randomized traffic
    arb_cycle(w);
    for (int n = 0; n < 150; n++) begin
      xfer($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), w);
      if (n != 149) arb_cycle(w);
    end

    // asynchronous reset during an ACCESS wait state
    next_req(1'b0, 1'b0);
    drive();
    step();
    mon_en = 1'b0;
    vld[0] = 1'b1;
    drive();
    apbm_ready = 1'b0;
    repeat (3) begin
      step();
      drive();
      apbm_ready = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", {req_done, grant, req_err, timeout_evt, apbm_sel, apbm_enable,
                        apbm_write, apbm_addr, apbm_wdata, req_rdata}, '0);
    vld[0] = 1'b0;
    vld[1] = 1'b1;
    drive();
    step();
    chk("held_reset", {req_done, grant, apbm_sel, apbm_enable, apbm_addr}, '0);
    step();
    rst_n = 1'b1;
    last_w = N - 1;
    mon_en = 1'b1;
    xfer(1, 32'h5A5A_A5A5, 1'b0, 1'b0, w);

    next_req(1'b0, 1'b0);
    drive();
    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
